mc_ctrl: RTL



---
 rtl/mc_pkg.sv | 59 +++++
 rtl/mc_if.sv | 33 +++
 rtl/mc_decode.sv | 44 ++++
 rtl/mc_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller.
// Holds the state enum, opcode/funct constants, datapath select encodings and the instruction class.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_LUI  = 3'd3;

  localparam logic [1:0] NPC_SEQ  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JMP  = 2'd2;
  localparam logic [1:0] NPC_JR   = 2'd3;

  localparam logic [1:0] RD_RT    = 2'd0;
  localparam logic [1:0] RD_RD    = 2'd1;
  localparam logic [1:0] RD_RA    = 2'd2;

  localparam logic [1:0] WD_ALU   = 2'd0;
  localparam logic [1:0] WD_MEM   = 2'd1;
  localparam logic [1:0] WD_PC4   = 2'd2;

  // One-hot instruction class; all-zero means the encoding is unsupported.
  typedef struct packed {
    logic nop;
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
  } icls_t;

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath bundle: IR, ALU flag and memory handshake in, strobes and selects out.
// master is the controller side, slave is the datapath side.
interface mc_if;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        pc_write;
  logic [1:0]  npc_sel;
  logic        ir_write;
  logic        ext_signed;
  logic [2:0]  alu_op;
  logic        alu_src_b;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic [1:0]  wd_sel;
  logic        instr_done;
  logic        illegal;
  logic [2:0]  state;

  modport master (
    input  instr, zero, mem_ready,
    output pc_write, npc_sel, ir_write, ext_signed, alu_op, alu_src_b,
           mem_read, mem_write, reg_write, reg_dst, wd_sel, instr_done, illegal, state
  );

  modport slave (
    output instr, zero, mem_ready,
    input  pc_write, npc_sel, ir_write, ext_signed, alu_op, alu_src_b,
           mem_read, mem_write, reg_write, reg_dst, wd_sel, instr_done, illegal, state
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational IR decode into a one-hot class, extender signedness and a legal flag.
// Pure logic, zero latency; no handshake.
module mc_decode import mc_pkg::*; (
  input  logic [31:0] instr_i,
  output icls_t       cls_o,
  output logic        ext_signed_o,
  output logic        legal_o
);
  logic [5:0] op;
  logic [5:0] funct;

  assign op    = instr_i[31:26];
  assign funct = instr_i[5:0];

  always_comb begin
    cls_o = '0;
    // The all-zero word is sll $0,$0,0; only that exact word is treated as a nop.
    if (instr_i == 32'd0) begin
      cls_o.nop = 1'b1;
    end else begin
      case (op)
        OP_RTYPE: begin
          case (funct)
            FN_ADDU: cls_o.addu = 1'b1;
            FN_SUBU: cls_o.subu = 1'b1;
            FN_JR:   cls_o.jr   = 1'b1;
            default: cls_o      = '0;
          endcase
        end
        OP_ORI:  cls_o.ori = 1'b1;
        OP_LUI:  cls_o.lui = 1'b1;
        OP_LW:   cls_o.lw  = 1'b1;
        OP_SW:   cls_o.sw  = 1'b1;
        OP_BEQ:  cls_o.beq = 1'b1;
        OP_J:    cls_o.j   = 1'b1;
        OP_JAL:  cls_o.jal = 1'b1;
        default: cls_o     = '0;
      endcase
    end
  end

  assign ext_signed_o = cls_o.lw | cls_o.sw | cls_o.beq;
  assign legal_o      = |cls_o;
endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: sequences FETCH/DECODE/EXEC/MEM/WB and drives all datapath strobes.
// Outputs decode from state and IR in the same cycle; memory states stall while mem_ready is low.
module mc_ctrl import mc_pkg::*; (
  input  logic  clk,
  input  logic  reset,
  mc_if.master  bus
);
  state_e state_q, state_d;
  icls_t  cls;
  logic   dec_ext_signed;
  logic   legal;

  logic       pc_write, ir_write, mem_read, mem_write, reg_write;
  logic       instr_done, illegal, alu_src_b, ext_signed;
  logic [1:0] npc_sel, reg_dst, wd_sel;
  logic [2:0] alu_op;

  mc_decode u_decode (
    .instr_i      (bus.instr),
    .cls_o        (cls),
    .ext_signed_o (dec_ext_signed),
    .legal_o      (legal)
  );

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    npc_sel    = NPC_SEQ;
    ir_write   = 1'b0;
    alu_op     = ALU_ADD;
    alu_src_b  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = RD_RT;
    wd_sel     = WD_ALU;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (cls.nop) begin
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end else if (!legal) begin
          illegal = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_src_b = cls.ori | cls.lui | cls.lw | cls.sw;
        if (cls.subu || cls.beq)  alu_op = ALU_SUB;
        else if (cls.ori)         alu_op = ALU_OR;
        else if (cls.lui)         alu_op = ALU_LUI;
        else                      alu_op = ALU_ADD;
        if (cls.lw || cls.sw) begin
          state_d = ST_MEM;
        end else if (cls.beq || cls.j || cls.jal || cls.jr) begin
          // Control transfers retire straight out of EXEC; beq only loads PC when taken.
          pc_write   = cls.beq ? bus.zero : 1'b1;
          npc_sel    = cls.beq ? NPC_BR : (cls.jr ? NPC_JR : NPC_JMP);
          reg_write  = cls.jal;
          reg_dst    = cls.jal ? RD_RA : RD_RT;
          wd_sel     = cls.jal ? WD_PC4 : WD_ALU;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_read  = cls.lw;
        mem_write = cls.sw;
        if (bus.mem_ready) begin
          if (cls.lw) begin
            state_d = ST_WB;
          end else begin
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (cls.addu || cls.subu) ? RD_RD : RD_RT;
        wd_sel     = cls.lw ? WD_MEM : WD_ALU;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    // IR is stale during FETCH, so the extender select is only driven once decoding starts.
    ext_signed = (state_q != ST_FETCH) && dec_ext_signed;

    // Reset kills any in-flight access or write in the same cycle it is raised.
    if (reset) begin
      pc_write   = 1'b0;
      npc_sel    = NPC_SEQ;
      ir_write   = 1'b0;
      ext_signed = 1'b0;
      alu_op     = ALU_ADD;
      alu_src_b  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = RD_RT;
      wd_sel     = WD_ALU;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  assign bus.pc_write   = pc_write;
  assign bus.npc_sel    = npc_sel;
  assign bus.ir_write   = ir_write;
  assign bus.ext_signed = ext_signed;
  assign bus.alu_op     = alu_op;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.reg_write  = reg_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.wd_sel     = wd_sel;
  assign bus.instr_done = instr_done;
  assign bus.illegal    = illegal;
  assign bus.state      = state_q;
endmodule
